serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial, multi-cycle two's-complement subtractor: diff = a - b, one bit per clock, LSB first.
//  Uses a single 1-bit full-subtractor cell plus a borrow flip-flop in place of a WIDTH-stage ripple chain.
//  Trades latency for area; it is the inverse-operation companion to the parallel ripple-carry adder.
//  Sits behind a start/done handshake so a sequencer or FSM can issue operations to it.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range 2..32
// PORTS
//  clk         in   1      rising-edge clock, single clock domain
//  reset       in   1      synchronous, active-high reset
//  start       in   1      request an operation; sampled only in IDLE or DONE
//  a           in   WIDTH  minuend; captured on the accepting edge
//  b           in   WIDTH  subtrahend; captured on the accepting edge
//  busy        out  1      high while an operation is in progress (SHIFT state)
//  done        out  1      one-cycle pulse: results valid
//  diff        out  WIDTH  a - b mod 2^WIDTH; held until the next completion
//  borrowout   out  1      1 if unsigned a < b
//  overflow    out  1      signed overflow: a[MSB]!=b[MSB] && diff[MSB]!=a[MSB]
// BEHAVIOUR
//  Reset (sync, active-high): state=IDLE; busy, done, borrowout and overflow = 0; diff = 0; internal regs cleared.
//    Reset overrides start and aborts any operation in progress; no done pulse follows an aborted operation.
//  FSM states:
//    IDLE: start=1 -> latch a,b into shift regs, borrow_ff=0, bit_cnt=0 -> SHIFT. Otherwise stay.
//    SHIFT: each edge, cell(x=a_sr[0], y=b_sr[0], bin=borrow_ff) gives d,bout.
//      d shifts into the MSB of the result reg; a_sr,b_sr shift right; borrow_ff<=bout; bit_cnt++.
//      On the edge that processes bit WIDTH-1: diff<=final result, borrowout<=bout,
//        overflow per rule above (uses latched a,b MSBs) -> DONE.
//    DONE: done=1 for exactly this cycle. start=1 -> accept new op (as IDLE) -> SHIFT. Else -> IDLE.
//  Latency: if start is accepted at edge k, results update and done rises at edge k+WIDTH.
//    busy is high for cycles k..k+WIDTH-1 (WIDTH cycles).
//  Throughput: back-to-back one op per WIDTH+1 cycles (start held high through DONE).
//  start while busy: ignored; operands not re-latched; in-flight op is unaffected.
//  a and b may change freely after the accepting edge.
//  diff, borrowout and overflow change only at completion or reset; they are stable through IDLE.
//  Cell equations: d = x ^ y ^ bin; bout = (~x & y) | (~x & bin) | (y & bin).
//  bit_cnt width = $clog2(WIDTH); no wrap beyond WIDTH-1 (SHIFT exits first).
//  Outputs are driven from registers; no combinational path from inputs to outputs.
// STRUCTURE
//  Shared package (serial_arith_pkg): state encoding localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
//    ST_DONE is reused by future serial arithmetic blocks.
//  Sub-module: full_subtractor (1-bit combinational cell: x, y, bin -> d, bout), instantiated once.
//  Top level contains the FSM, the two operand shift regs, the result shift reg, borrow_ff and bit_cnt.
// TESTING (WIDTH=8 unless noted)
//  1. a=0x05, b=0x03, start 1 cycle
//     -> done at edge k+8, diff=0x02, borrowout=0, overflow=0; busy high 8 cycles.
//  2. a=0x03, b=0x05 -> diff=0xFE, borrowout=1, overflow=0.
//     a=0x00, b=0x00 -> diff=0x00, borrowout=0, overflow=0.
//  3. Signed edges: a=0x80, b=0x01 -> diff=0x7F, overflow=1, borrowout=0.
//     a=0x7F, b=0xFF -> diff=0x80, overflow=1, borrowout=1.
//  4. start pulsed with new a,b at cycle k+3 of an op
//     -> ignored; first result correct; no second done without a new start.
//  5. reset asserted at cycle k+4 -> next cycle busy=0, done=0, diff=0x00, borrowout=0; no done pulse;
//     a new start is then accepted normally.
//  6. Back-to-back: start held high, pairs (0x10,0x01), (0x01,0x10)
//     -> done pulses 9 cycles apart; diffs 0x0F then 0xF1 (borrowout 0 then 1).
//     Also run a random 1000-op sweep at WIDTH=4 and WIDTH=16 against a reference model.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
// Holds the state encoding that the serial units use, so their DONE states line up.
package serial_arith_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StShift = ST_SHIFT,
    StDone  = ST_DONE
  } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus of the serial subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrowout;
  logic             overflow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrowout, overflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrowout, overflow
  );

endinterface

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: d = x - y - bin, with borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first,
// behind a start/done handshake. A single full-subtractor cell is reused every cycle.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  serial_subtractor_if.slave bus
);

  localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             cell_d, cell_bout;

  full_subtractor u_cell (
    .x    (a_sr_q[0]),
    .y    (b_sr_q[0]),
    .bin  (borrow_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (bus.start) begin
          a_sr_d   = bus.a;
          b_sr_d   = bus.b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = StShift;
        end
      end
      StShift: begin
        res_d    = {cell_d, res_q[WIDTH-1:1]};
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        borrow_d = cell_bout;
        if (cnt_q == LastCnt) begin
          // On the last bit the cell inputs are the operand MSBs.
          diff_d  = {cell_d, res_q[WIDTH-1:1]};
          bout_d  = cell_bout;
          ovf_d   = (a_sr_q[0] != b_sr_q[0]) && (cell_d != a_sr_q[0]);
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy      = (state_q == StShift);
  assign bus.done      = (state_q == StDone);
  assign bus.diff      = diff_q;
  assign bus.borrowout = bout_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboarded bench for serial_subtractor: directed cases at WIDTH=8, random sweeps at 4 and 16.
module tb_serial_subtractor;

  typedef struct {
    logic [31:0] diff;
    logic        bout;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q8[$];
  exp_t q4[$];
  exp_t q16[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_subtractor_if #(.WIDTH(8))  bus8 ();
  serial_subtractor_if #(.WIDTH(4))  bus4 ();
  serial_subtractor_if #(.WIDTH(16)) bus16 ();

  serial_subtractor #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8.slave));
  serial_subtractor #(.WIDTH(4))  dut4  (.clk(clk), .reset(reset), .bus(bus4.slave));
  serial_subtractor #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16.slave));

  // Reference: plain modular and signed integer arithmetic.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input int done_cyc);
    longint m, half, ua, ub, sa, sb, sd;
    exp_t e;
    m    = longint'(1) << w;
    half = m / 2;
    ua   = longint'(a) & (m - 1);
    ub   = longint'(b) & (m - 1);
    sa   = (ua >= half) ? ua - m : ua;
    sb   = (ub >= half) ? ub - m : ub;
    sd   = sa - sb;
    e.diff = 32'((ua - ub + m) % m);
    e.bout = (ua < ub);
    e.ovf  = (sd < -half) || (sd >= half);
    e.cyc  = done_cyc;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic chk_result(input string tag, input logic [31:0] diff, input logic bout,
                            input logic ovf, input exp_t e);
    chk({tag, "_diff"}, diff, e.diff);
    chk({tag, "_borrowout"}, 32'(bout), 32'(e.bout));
    chk({tag, "_overflow"}, 32'(ovf), 32'(e.ovf));
    chk({tag, "_done_cycle"}, cyc, e.cyc);
  endtask

  task automatic unexpected(input string tag);
    checks++;
    errors++;
    $display("FAIL %s unexpected done got 1 expected 0 (cycle %0d)", tag, cyc);
  endtask

  // Monitors: pop the oldest expectation whenever a done pulse is seen.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus8.done) begin
      if (q8.size() == 0) unexpected("w8");
      else begin
        e = q8.pop_front();
        chk_result("w8", 32'(bus8.diff), bus8.borrowout, bus8.overflow, e);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus4.done) begin
      if (q4.size() == 0) unexpected("w4");
      else begin
        e = q4.pop_front();
        chk_result("w4", 32'(bus4.diff), bus4.borrowout, bus4.overflow, e);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus16.done) begin
      if (q16.size() == 0) unexpected("w16");
      else begin
        e = q16.pop_front();
        chk_result("w16", 32'(bus16.diff), bus16.borrowout, bus16.overflow, e);
      end
    end
  end

  function automatic int width_of(input int idx);
    return (idx == 0) ? 8 : (idx == 1) ? 4 : 16;
  endfunction

  function automatic int qsize(input int idx);
    return (idx == 0) ? q8.size() : (idx == 1) ? q4.size() : q16.size();
  endfunction

  task automatic push(input int idx, input exp_t e);
    case (idx)
      0:       q8.push_back(e);
      1:       q4.push_back(e);
      default: q16.push_back(e);
    endcase
  endtask

  task automatic drive(input int idx, input logic s, input logic [31:0] a, input logic [31:0] b);
    case (idx)
      0:       begin bus8.start = s;  bus8.a = a[7:0];   bus8.b = b[7:0];   end
      1:       begin bus4.start = s;  bus4.a = a[3:0];   bus4.b = b[3:0];   end
      default: begin bus16.start = s; bus16.a = a[15:0]; bus16.b = b[15:0]; end
    endcase
  endtask

  // Drive start for one cycle on an idle unit; accepted on the next rising edge.
  task automatic issue(input int idx, input logic [31:0] a, input logic [31:0] b);
    int w;
    w = width_of(idx);
    @(negedge clk);
    drive(idx, 1'b1, a, b);
    push(idx, model(w, a, b, cyc + 1 + w));
    @(negedge clk);
    drive(idx, 1'b0, $urandom, $urandom);
  endtask

  task automatic wait_drain(input int idx, input int budget);
    int n;
    n = 0;
    while (qsize(idx) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (qsize(idx) != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_w%0d pending %0d expected 0 after %0d cycles", width_of(idx),
               qsize(idx), budget);
      case (idx)
        0:       q8.delete();
        1:       q4.delete();
        default: q16.delete();
      endcase
    end
  endtask

  task automatic sweep(input int idx, input int n_ops);
    for (int i = 0; i < n_ops; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(idx, $urandom, $urandom);
      wait_drain(idx, width_of(idx) + 6);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int   busy_cnt;
    int   c0;
    exp_t e;
    logic [7:0] pairs_a [4] = '{8'h03, 8'h00, 8'h80, 8'h7F};
    logic [7:0] pairs_b [4] = '{8'h05, 8'h00, 8'h01, 8'hFF};

    reset = 1'b1;
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus8.busy), 0);
    chk("rst_done", 32'(bus8.done), 0);
    chk("rst_diff", 32'(bus8.diff), 0);
    chk("rst_borrowout", 32'(bus8.borrowout), 0);
    chk("rst_overflow", 32'(bus8.overflow), 0);
    reset = 1'b0;

    // Basic op with busy-length measurement.
    @(negedge clk);
    drive(0, 1'b1, 32'h05, 32'h03);
    push(0, model(8, 32'h05, 32'h03, cyc + 9));
    busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) drive(0, 1'b0, $urandom, $urandom);
      busy_cnt += int'(bus8.busy);
    end
    chk("t1_busy_cycles", busy_cnt, 8);
    wait_drain(0, 20);

    for (int i = 0; i < 4; i++) begin
      issue(0, 32'(pairs_a[i]), 32'(pairs_b[i]));
      wait_drain(0, 20);
    end

    // start pulsed mid-operation must be ignored.
    @(negedge clk);
    drive(0, 1'b1, 32'h20, 32'h05);
    e = model(8, 32'h20, 32'h05, cyc + 9);
    push(0, e);
    @(negedge clk);
    drive(0, 1'b0, 32'h00, 32'h00);
    repeat (2) @(negedge clk);
    drive(0, 1'b1, 32'hAA, 32'h55);
    @(negedge clk);
    drive(0, 1'b0, 32'h00, 32'h00);
    wait_drain(0, 20);
    repeat (12) @(negedge clk);
    chk("t4_diff_held", 32'(bus8.diff), e.diff);
    chk("t4_busy_idle", 32'(bus8.busy), 0);

    // Reset mid-operation aborts without a done pulse.
    @(negedge clk);
    drive(0, 1'b1, 32'h44, 32'h11);
    push(0, model(8, 32'h44, 32'h11, cyc + 9));
    @(negedge clk);
    drive(0, 1'b0, 32'h00, 32'h00);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    q8.delete();
    @(negedge clk);
    chk("t5_busy", 32'(bus8.busy), 0);
    chk("t5_done", 32'(bus8.done), 0);
    chk("t5_diff", 32'(bus8.diff), 0);
    chk("t5_borrowout", 32'(bus8.borrowout), 0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    issue(0, 32'h09, 32'h0A);
    wait_drain(0, 20);

    // Back-to-back with start held high: done pulses WIDTH+1 apart.
    @(negedge clk);
    c0 = cyc;
    drive(0, 1'b1, 32'h10, 32'h01);
    push(0, model(8, 32'h10, 32'h01, c0 + 9));
    push(0, model(8, 32'h01, 32'h10, c0 + 18));
    @(negedge clk);
    drive(0, 1'b1, 32'h01, 32'h10);
    while (cyc < c0 + 10) @(negedge clk);
    drive(0, 1'b0, 32'h00, 32'h00);
    wait_drain(0, 30);
    repeat (12) @(negedge clk);

    fork
      sweep(1, 1000);
      sweep(2, 1000);
    join
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
